ifetch: RTL

Instruction fetch stage of the KLP32 RV32I core, directly upstream of decode and `immgen`. Holds the PC, issues word requests to instruction memory under a req/gnt + in-order rvalid protocol, and buffers returned words in a 2-entry FIFO. It presents each instruction to decode as `id_instr` with its `id_pc` and an `id_imm_sel` code that drives `immgen` directly. Branch/jump redirects flush the FIFO and discard responses still in flight.

---
 rtl/ifetch_if.sv | 51 +++++
 rtl/ifetch.sv | 135 +++++++++++++
 2 files changed

// File: rtl/ifetch_if.sv
// Bundle of the instruction-memory bus, the redirect port from execute and the
// decode handoff. The fetch stage uses the master view, its environment
// (memory, execute, decode) uses the slave view.
interface ifetch_if #(
  parameter int n = 32
);
  logic         imem_req;
  logic [n-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [n-1:0] imem_rdata;

  logic         redirect_valid;
  logic [n-1:0] redirect_pc;

  logic         id_valid;
  logic         id_ready;
  logic [n-1:0] id_instr;
  logic [n-1:0] id_pc;
  logic [2:0]   id_imm_sel;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc,
    output id_imm_sel
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc,
    input  id_imm_sel
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage of the KLP32 core.
// Holds the PC, issues word fetches under req/gnt with in-order rvalid
// responses, and queues returned words in a 2-entry FIFO toward decode.
// Requests are only issued when a FIFO slot is guaranteed for the response
// (outstanding + buffered - leaving < 2), so the FIFO can never overflow.
// A redirect flushes the FIFO and marks every still-outstanding response
// for discard through the kill counter.
module ifetch #(
  parameter int           n        = 32,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input logic      clk,
  input logic      rst_n,
  ifetch_if.master bus
);

  typedef struct packed {
    logic [n-1:0] instr;
    logic [n-1:0] pc;
  } entry_t;

  logic [n-1:0] pc;
  logic [1:0]   out_cnt;
  logic [1:0]   kill;
  logic [1:0]   occ;
  entry_t       fifo_q [2];
  logic [n-1:0] addr_q [2];

  logic         pop;
  logic         resp;
  logic         drop;
  logic         push;
  logic         req;
  logic         grant;
  logic [2:0]   credit_sum;
  logic [1:0]   out_next;
  logic         fifo_wr_idx;
  logic         addr_wr_idx;
  logic [n-1:0] redirect_target;
  logic [2:0]   imm_sel;

  // Handshake decode: credit check, response classification and write slots.
  always_comb begin
    pop        = (occ != 2'd0) & bus.id_ready;
    resp       = bus.imem_rvalid & (out_cnt != 2'd0);
    drop       = resp & (kill != 2'd0);
    push       = resp & (kill == 2'd0) & ~bus.redirect_valid;
    credit_sum = {1'b0, out_cnt} + {1'b0, occ} - {2'b00, pop};
    req        = rst_n & ~bus.redirect_valid & (credit_sum < 3'd2);
    grant      = req & bus.imem_gnt;
    out_next   = out_cnt + {1'b0, grant} - {1'b0, resp};
    // Slot for an incoming word once any same-cycle pop has shifted the FIFO.
    fifo_wr_idx = (occ == 2'd2) | ((occ == 2'd1) & ~pop);
    // Slot for a newly granted address once any same-cycle response has shifted.
    addr_wr_idx = (out_cnt == 2'd2) | ((out_cnt == 2'd1) & ~resp);
    redirect_target = bus.redirect_pc & ~n'(32'd3);
  end

  // PC, outstanding-request count and discard count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      out_cnt <= 2'd0;
      kill    <= 2'd0;
    end else begin
      out_cnt <= out_next;
      if (bus.redirect_valid) begin
        pc   <= redirect_target;
        kill <= out_next;
      end else begin
        if (grant) begin
          pc <= pc + n'(32'd4);
        end
        if (drop) begin
          kill <= kill - 2'd1;
        end
      end
    end
  end

  // In-flight fetch addresses, head is the address of the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q[0] <= '0;
      addr_q[1] <= '0;
    end else begin
      if (resp) begin
        addr_q[0] <= addr_q[1];
      end
      if (grant) begin
        addr_q[addr_wr_idx] <= pc;
      end
    end
  end

  // Instruction FIFO toward decode; head lives in entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ       <= 2'd0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else if (bus.redirect_valid) begin
      occ <= 2'd0;
    end else begin
      if (pop) begin
        fifo_q[0] <= fifo_q[1];
      end
      if (push) begin
        fifo_q[fifo_wr_idx] <= '{instr: bus.imem_rdata, pc: addr_q[0]};
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  // Immediate format for immgen, decoded from the head opcode.
  always_comb begin
    imm_sel = 3'b000;
    case (fifo_q[0].instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: imm_sel = 3'b000;
      7'b0100011:                         imm_sel = 3'b001;
      7'b1100011:                         imm_sel = 3'b010;
      7'b0110111, 7'b0010111:             imm_sel = 3'b011;
      7'b1101111:                         imm_sel = 3'b100;
      default:                            imm_sel = 3'b000;
    endcase
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc;
  assign bus.id_valid   = (occ != 2'd0);
  assign bus.id_instr   = fifo_q[0].instr;
  assign bus.id_pc      = fifo_q[0].pc;
  assign bus.id_imm_sel = imm_sel;

endmodule
